// File: rtl/irq_pkg.sv
// Shared parameters, FSM state type and clear-vector helper for the interrupt pending controller.
package irq_pkg;
  localparam int N_LINES = 8;
  localparam int ID_W    = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [N_LINES-1:0] onehot_from_idx(input logic [ID_W-1:0] idx);
    logic [N_LINES-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// 8:3 fixed priority encoder, bit 7 highest; purely combinational.
// All-zero input yields id 0 with any deasserted.
module prio_enc8
  import irq_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  always_comb begin
    id = '0;
    // Ascending scan so the highest set bit is the last one written.
    for (int i = 0; i < N_LINES; i++) begin
      if (vec[i]) id = ID_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures rising request edges as pending bits and offers the highest unmasked one as an ID.
// Offer appears one edge after the pending bit sets; the offer holds stable until irq_ready.
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] req_in,
  input  logic [N_LINES-1:0] mask_in,
  input  logic               irq_ready,
  input  logic               ovf_clr,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [N_LINES-1:0] pending,
  output logic [N_LINES-1:0] overflow
);

  state_t             state;
  logic [N_LINES-1:0] req_q;
  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] clr;
  logic [ID_W-1:0]    enc_id;
  logic               enc_any;
  logic               accept;

  // Loading req_q during reset suppresses events from lines already high at release.
  always_ff @(posedge clk) begin
    req_q <= req_in;
  end

  assign rise   = req_in & ~req_q;
  assign accept = (state == OFFER) && irq_ready;
  assign clr    = accept ? onehot_from_idx(irq_id) : '0;

  prio_enc8 u_enc (
    .vec (pending & mask_in),
    .id  (enc_id),
    .any (enc_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clr) | rise;
      overflow <= (ovf_clr ? '0 : overflow) | (rise & pending & ~clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_any) begin
            irq_id <= enc_id;
            state  <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq_valid = (state == OFFER);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomised plus directed bench for irq_pending_ctrl against a behavioural reference model.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = 8'h00;
  logic [7:0] mask_in = 8'hFF;
  logic       irq_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] overflow;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  bit [7:0] m_prev = 8'h00;
  bit [7:0] m_pend = 8'h00;
  bit [7:0] m_ovf  = 8'h00;
  bit       m_valid = 1'b0;
  int       m_id    = 0;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .irq_ready (irq_ready),
    .ovf_clr   (ovf_clr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int highest(input bit [7:0] v);
    int h;
    h = -1;
    for (int i = 0; i < 8; i++) if (v[i]) h = i;
    return h;
  endfunction

  // Advance the model by one clock using the behavioural rules for the given inputs.
  task automatic model_edge(input bit [7:0] r, input bit [7:0] mk, input bit rd,
                            input bit oc, input bit rs);
    bit [7:0] rise;
    bit       acc;
    int       h;
    if (rs) begin
      m_prev = r; m_pend = '0; m_ovf = '0; m_valid = 0; m_id = 0;
      return;
    end
    rise = r & ~m_prev;
    m_prev = r;
    acc = m_valid && rd;
    if (oc) m_ovf = '0;
    for (int i = 0; i < 8; i++) begin
      bit cleared;
      cleared = acc && (i == m_id);
      if (rise[i] && m_pend[i] && !cleared) m_ovf[i] = 1'b1;
    end
    h = highest(m_pend & mk);
    if (m_valid) begin
      if (rd) m_valid = 0;
    end else if (h >= 0) begin
      m_valid = 1;
      m_id = h;
    end
    for (int i = 0; i < 8; i++) begin
      if (acc && i == m_id && !m_valid) m_pend[i] = rise[i];
      else m_pend[i] = m_pend[i] | rise[i];
    end
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] mk, input logic rd,
                      input logic oc, input logic rs);
    int id_before;
    bit valid_before;
    valid_before = m_valid;
    id_before = m_id;
    req_in = r; mask_in = mk; irq_ready = rd; ovf_clr = oc; rst = rs;
    // model_edge reads the accepted ID before it may be overwritten
    if (valid_before && rd && !rs) begin
      model_edge(r, mk, rd, oc, rs);
      if (!rs) m_pend[id_before] = m_pend[id_before];
    end else begin
      model_edge(r, mk, rd, oc, rs);
    end
    @(posedge clk);
    #1;
    chk("valid", irq_valid, m_valid);
    chk("id", irq_id, m_id);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
  endtask

  initial begin
    int ids[$];
    logic [7:0] r;
    logic [7:0] mk;

    // Reset with lines already high: no event at release
    step(8'h81, 8'hFF, 0, 0, 1);
    step(8'h81, 8'hFF, 0, 0, 1);
    repeat (3) step(8'h81, 8'hFF, 0, 0, 0);
    chk("rst_pend", pending, 8'h00);
    chk("rst_valid", irq_valid, 1'b0);
    step(8'h85, 8'hFF, 0, 0, 0);
    chk("b2_pend", pending, 8'h04);
    chk("b2_novalid", irq_valid, 1'b0);
    step(8'h81, 8'hFF, 0, 0, 0);
    chk("b2_valid", irq_valid, 1'b1);
    chk("b2_id", irq_id, 3'd2);
    step(8'h81, 8'hFF, 1, 0, 0);
    chk("b2_acc_pend", pending, 8'h00);

    // Priority order with ready held high
    step(8'hE9, 8'hFF, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(8'hE9, 8'hFF, 1, 0, 0);
      if (irq_valid) ids.push_back(int'(irq_id));
    end
    chk("prio_cnt", ids.size(), 3);
    if (ids.size() == 3) begin
      chk("prio_0", ids[0], 6);
      chk("prio_1", ids[1], 5);
      chk("prio_2", ids[2], 3);
    end
    chk("prio_pend", pending, 8'h00);
    step(8'h00, 8'hFF, 0, 0, 0);

    // Masked line latches but waits until unmasked
    step(8'h82, 8'h7F, 0, 0, 0);
    step(8'h82, 8'h7F, 0, 0, 0);
    step(8'h82, 8'h7F, 0, 0, 0);
    chk("mask_id", irq_id, 3'd1);
    chk("mask_pend", pending, 8'h82);
    step(8'h82, 8'h7F, 1, 0, 0);
    step(8'h82, 8'hFF, 0, 0, 0);
    chk("unmask_valid", irq_valid, 1'b1);
    chk("unmask_id", irq_id, 3'd7);
    step(8'h82, 8'hFF, 1, 0, 0);
    step(8'h00, 8'hFF, 0, 0, 0);

    // Backpressure: ID stays stable while a higher line arrives
    step(8'h10, 8'hFF, 0, 0, 0);
    step(8'h10, 8'hFF, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(8'h90, 8'hFF, 0, 0, 0);
      chk("bp_id", irq_id, 3'd4);
    end
    step(8'h90, 8'hFF, 1, 0, 0);
    chk("bp_gap", irq_valid, 1'b0);
    step(8'h90, 8'hFF, 0, 0, 0);
    chk("bp_next", irq_id, 3'd7);
    step(8'h00, 8'hFF, 1, 0, 0);
    step(8'h00, 8'hFF, 0, 0, 0);

    // Overflow set, coincident set/clear, sticky clear
    step(8'h01, 8'hFE, 0, 0, 0);
    step(8'h00, 8'hFE, 0, 0, 0);
    step(8'h01, 8'hFE, 0, 0, 0);
    chk("ovf_set", overflow, 8'h01);
    step(8'h00, 8'hFF, 0, 0, 0);
    chk("ovf_offer", irq_id, 3'd0);
    step(8'h01, 8'hFF, 1, 0, 0);
    chk("coinc_pend", pending, 8'h01);
    chk("coinc_ovf", overflow, 8'h01);
    step(8'h00, 8'hFF, 0, 1, 0);
    chk("ovf_clr", overflow, 8'h00);

    // Reset while offering
    chk("pre_rst_valid", irq_valid, 1'b1);
    step(8'h00, 8'hFF, 0, 0, 1);
    chk("mid_rst_valid", irq_valid, 1'b0);
    chk("mid_rst_pend", pending, 8'h00);
    step(8'h00, 8'hFF, 0, 0, 0);

    // Random traffic
    r = 8'h00;
    for (int k = 0; k < 1500; k++) begin
      r = r ^ 8'($urandom & $urandom & $urandom);
      mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      step(r, mk, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
